// File: rtl/c5_fc_engine.sv
// c5_fc_engine: LeNet C5 fully connected layer, 400 inputs into 120 parallel MAC lanes, ReLU + requantised streaming out.
module c5_fc_engine #(
  parameter int N_IN  = 400,
  parameter int N_OUT = 120,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7,
  localparam int AW   = $clog2(N_IN),
  localparam int IW   = $clog2(N_OUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [AW-1:0]         feat_raddr,
  input  logic signed [DW-1:0]  feat_rdata,
  output logic [AW-1:0]         w5_raddr,
  input  logic [N_OUT*DW-1:0]   w5_rdata,
  output logic                  c5_valid,
  input  logic                  c5_ready,
  output logic [IW-1:0]         c5_idx,
  output logic [DW-1:0]         c5_data,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, OUT, FIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic vld_q, clr, accept;
  logic signed [2*DW-1:0] prod [N_OUT];
  logic signed [ACC_W-1:0] acc_q [N_OUT];
  logic signed [ACC_W-1:0] acc_d [N_OUT];
  logic signed [ACC_W-1:0] sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vld_q   <= state_q == MAC;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end
  // Accumulators are cleared on start, so they carry no reset.
  always_ff @(posedge clk) acc_q <= acc_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? MAC : IDLE;
      MAC:     state_d = (addr_q == AW'(N_IN - 1)) ? DRAIN : MAC;
      DRAIN:   state_d = OUT;
      OUT:     state_d = (c5_ready && idx_q == IW'(N_OUT - 1)) ? FIN : OUT;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy     = state_q != IDLE;
    c5_valid = state_q == OUT;
    done     = state_q == FIN;
  end
  assign feat_raddr = addr_q;
  assign w5_raddr   = addr_q;
  assign c5_idx     = idx_q;
  assign c5_data    = data_q;
  assign clr        = state_q == IDLE && start;
  assign accept     = state_q == OUT && c5_ready;
  always_comb begin
    addr_d = clr ? '0 : (state_q == MAC && addr_q != AW'(N_IN - 1)) ? addr_q + AW'(1) : addr_q;
    idx_d  = state_q == DRAIN ? '0 : accept ? (idx_q == IW'(N_OUT - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    for (int i = 0; i < N_OUT; i++) begin
      prod[i]  = feat_rdata * $signed(w5_rdata[i*DW +: DW]);
      acc_d[i] = clr ? '0 : vld_q ? acc_q[i] + {{(ACC_W-2*DW){prod[i][2*DW-1]}}, prod[i]} : acc_q[i];
    end
  end
  // Result is taken from next-state accumulators so the final product is already included at DRAIN.
  always_comb begin
    sel    = acc_d[idx_d];
    data_d = (state_q == DRAIN || state_q == OUT)
           ? (sel[ACC_W-1] ? '0
             : |sel[ACC_W-2:SHIFT+DW-1] ? {1'b0, {(DW-1){1'b1}}}
             : {1'b0, sel[SHIFT +: DW-1]})
           : data_q;
  end
endmodule

// File: tb/tb_c5_fc_engine.sv
// tb_c5_fc_engine: directed passes checked every cycle against a per-pass dot-product model and timeline.
module tb_c5_fc_engine;
  localparam int N_IN = 400, N_OUT = 120, DW = 8;
  logic clk = 0, rst = 1, start = 0, c5_ready = 0;
  logic busy, c5_valid, done;
  logic [8:0] feat_raddr, w5_raddr;
  logic [7:0] feat_rdata;
  logic [N_OUT*DW-1:0] w5_rdata;
  logic [6:0] c5_idx;
  logic [7:0] c5_data;
  int errors = 0, checks = 0;
  int mode = 0, rdy_mode = 0;
  int exp_data [N_OUT];
  int cap [N_OUT];
  bit active = 0, prev_rst = 0;
  int cyc = 0, acc_cnt = 0, done_cyc = 0;

  always #5 clk = ~clk;

  c5_fc_engine dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .feat_raddr(feat_raddr), .feat_rdata(feat_rdata),
    .w5_raddr(w5_raddr), .w5_rdata(w5_rdata),
    .c5_valid(c5_valid), .c5_ready(c5_ready),
    .c5_idx(c5_idx), .c5_data(c5_data), .done(done)
  );

  function automatic int fval(int m, int a);
    return m == 0 ? 1 : m == 1 ? 127 : m == 2 ? 64 : a % 5;
  endfunction

  function automatic int wval(int m, int a, int i);
    return m == 0 ? 1 : m == 1 ? 127 : m == 2 ? ((i % 2 == 0) ? -1 : 2) : i - 60;
  endfunction

  always @(posedge clk) begin
    feat_rdata <= 8'(fval(mode, int'(feat_raddr)));
    for (int i = 0; i < N_OUT; i++) w5_rdata[i*DW +: DW] <= 8'(wval(mode, int'(w5_raddr), i));
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_mode(input int m);
    int s, v;
    logic signed [23:0] t;
    mode = m;
    for (int i = 0; i < N_OUT; i++) begin
      s = 0;
      for (int a = 0; a < N_IN; a++) s += fval(m, a) * wval(m, a, i);
      t = 24'(s);
      v = int'(t);
      v = v < 0 ? 0 : v / 128;
      exp_data[i] = v > 127 ? 127 : v;
    end
  endtask

  always @(negedge clk) begin
    if (prev_rst) begin
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(c5_valid), 0);
      check("rst_done", int'(done), 0);
      check("rst_idx", int'(c5_idx), 0);
      check("rst_data", int'(c5_data), 0);
      check("rst_faddr", int'(feat_raddr), 0);
      check("rst_waddr", int'(w5_raddr), 0);
    end else if (active) begin
      cyc++;
      check("busy", int'(busy), 1);
      check("addr", int'(feat_raddr), cyc <= N_IN ? cyc - 1 : N_IN - 1);
      check("waddr", int'(w5_raddr), int'(feat_raddr));
      check("valid", int'(c5_valid), int'(cyc >= N_IN + 2 && acc_cnt < N_OUT));
      check("done", int'(done), int'(acc_cnt == N_OUT));
      if (c5_valid && cyc >= N_IN + 2 && acc_cnt < N_OUT) begin
        check("idx", int'(c5_idx), acc_cnt);
        check("data", int'(c5_data), exp_data[acc_cnt]);
      end
      if (c5_valid && c5_ready) begin
        cap[c5_idx] = int'(c5_data);
        acc_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        active = 0;
      end
      if (cyc > 3000) begin
        check("pass_bound", 0, 1);
        active = 0;
      end
    end else begin
      check("idle_busy", int'(busy), 0);
      check("idle_valid", int'(c5_valid), 0);
      check("idle_done", int'(done), 0);
      if (start && !rst) begin
        active = 1;
        cyc = 0;
        acc_cnt = 0;
      end
    end
    prev_rst = rst;
    if (rst) active = 0;
  end

  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      c5_ready = (rdy_mode == 0) ? 1'b1 : (k % 4 == 0 || k % 4 == 3);
      k++;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cyc == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cyc == 0) check("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    set_mode(0);
    check("model_ones", exp_data[7], 3);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    done_cyc = 0;
    pulse_start();
    wait_done();
    check("done_cycle_ones", done_cyc, 522);
    check("cap_ones_0", cap[0], 3);
    check("cap_ones_119", cap[119], 3);

    set_mode(1);
    check("model_sat", exp_data[50], 127);
    done_cyc = 0;
    pulse_start();
    wait_done();
    check("cap_sat_50", cap[50], 127);

    set_mode(2);
    check("model_relu_even", exp_data[4], 0);
    done_cyc = 0;
    pulse_start();
    wait_done();
    check("cap_relu_0", cap[0], 0);
    check("cap_odd_1", cap[1], 127);

    set_mode(3);
    check("model_ramp_61", exp_data[61], 6);
    check("model_ramp_80", exp_data[80], 125);
    rdy_mode = 1;
    done_cyc = 0;
    pulse_start();
    wait_done();
    check("cap_ramp_59", cap[59], 0);
    check("cap_ramp_61", cap[61], 6);
    check("cap_ramp_80", cap[80], 125);
    check("cap_ramp_81", cap[81], 127);
    check("stall_done_late", int'(done_cyc > 522), 1);
    rdy_mode = 0;

    done_cyc = 0;
    pulse_start();
    repeat (199) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    repeat (5) @(posedge clk);
    check("abort_no_done", done_cyc, 0);
    set_mode(0);
    for (int i = 0; i < N_OUT; i++) cap[i] = -1;
    done_cyc = 0;
    pulse_start();
    wait_done();
    check("post_abort_done", done_cyc, 522);
    check("post_abort_0", cap[0], 3);
    check("post_abort_119", cap[119], 3);

    set_mode(3);
    done_cyc = 0;
    pulse_start();
    repeat (99) @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (309) @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done();
    check("ignored_start_done", done_cyc, 522);
    check("ignored_start_80", cap[80], 125);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/c5_fc_engine.md
# c5_fc_engine

Compute engine for the LeNet C5 layer, a 400-input by 120-output fully connected stage. It sits between the S4 pooled-feature buffer and the F6 layer. For each input feature it reads the feature from the buffer and the matching row of 120 weights from the w5 weight ROM, then accumulates into 120 parallel signed accumulators. When all inputs are consumed it applies ReLU and requantisation, then streams the 120 results to F6 over a valid/ready handshake.

## Interface
Parameters:
- N_IN, 400: input feature count; address range 0..N_IN-1.
- N_OUT, 120: output neuron count, equal to the number of parallel lanes.
- DW, 8: width of signed feature, weight and result values.
- ACC_W, 24: width of each signed accumulator.
- SHIFT, 7: right arithmetic shift used for requantisation.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous reset, active high.
- start, input, 1: one-cycle pulse that begins a layer pass. Accepted only in IDLE.
- busy, output, 1: high from the cycle after start is accepted until done.
- feat_raddr, output, 9: read address into the S4 feature buffer.
- feat_rdata, input, DW: signed feature. Valid 1 cycle after feat_raddr.
- w5_raddr, output, 9: read address into the w5 weight ROM. Always equal to feat_raddr.
- w5_rdata, input, N_OUT*DW: packed weight row, valid 1 cycle after w5_raddr. Slice [i*8+7:i*8] is the weight for neuron i (0-based).
- c5_valid, output, 1: a result is presented on c5_data.
- c5_ready, input, 1: F6 accepts the current result.
- c5_idx, output, 7: neuron index of c5_data, 0..N_OUT-1.
- c5_data, output, DW: requantised result, range 0..127.
- done, output, 1: one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, MAC, DRAIN, OUT, FIN.
- IDLE:
  - On start=1, clear all accumulators, set the address counter to 0 and go to MAC.
  - start in any other state is ignored.
- MAC:
  - Drive feat_raddr and w5_raddr with the counter, then increment it.
  - After issuing address N_IN-1, go to DRAIN.
- Accumulate stage, one cycle behind address issue:
  - A registered addr_vld flag marks the cycle in which rdata is valid.
  - When addr_vld=1, for every lane i: acc[i] <= acc[i] + feat_rdata * w[i], as a signed DW×DW product sign-extended to ACC_W.
  - The accumulators wrap on overflow; there is no saturation inside the accumulator.
- DRAIN: one cycle in which the last product is accumulated. Then go to OUT with idx=0.
- OUT:
  - Registered output: c5_data = sat(max(acc[idx],0) >>> SHIFT), saturated to 127.
  - c5_valid=1. c5_idx and c5_data stay stable while c5_ready=0.
  - On c5_valid & c5_ready, idx increments and the next result appears on the following cycle.
  - Back-to-back acceptance gives one result per cycle.
  - Acceptance at idx=N_OUT-1 goes to FIN.
- FIN: done=1 for one cycle, then go to IDLE.
- Reset at any time, including mid-MAC or mid-OUT: the FSM goes to IDLE and all outputs take their reset values. The accumulators need no reset because they are cleared on start.

## Timing
- Reset values: busy=0, c5_valid=0, done=0, c5_idx=0, c5_data=0, feat_raddr=0, w5_raddr=0.
- Let start be sampled at cycle 0.
  - Addresses 0..399 are driven on cycles 1..400.
  - Accumulation happens on cycles 2..401.
  - The first c5_valid is on cycle 402.
- With c5_ready held at 1, the last result is accepted on cycle 521 and done pulses on cycle 522.
- busy=1 on cycles 1..522 and falls with done.
- Between passes the addresses hold their last value. Memory reads during IDLE are don't-care.
- Minimum start-to-start interval is 523 cycles plus any F6 back-pressure cycles.

## Test plan
- All features = 1 and all weights = 1: every acc = 400, and c5_data = 400>>7 = 3 for idx 0..119. done arrives on cycle 522.
- Feature = 127 and weight[i] = 127 for all i: acc = 6,451,600, and c5_data saturates to 127 on every lane.
- Weight[i] = -1 for even i and +2 for odd i, with features = 64: even lanes give 0 (ReLU), odd lanes give (51200>>7) = 400, saturated to 127.
- c5_ready toggles 1,0,0,1 while the engine sends results: each idx is emitted exactly once, in order, and data holds stable during stalls. done comes only after idx 119 is accepted.
- rst is asserted on cycle 200 during MAC: outputs are at reset values from cycle 201. A new start gives correct results with no residue from the aborted pass.
- start is pulsed again during MAC and again during OUT: both are ignored, and address sequence and results match an unperturbed pass.
